// File: rtl/kcpsmx_flow_ctl_pkg.sv
// Shared types for the KCPSMX pipeline flow controller.
//   STACK_DEPTH / SP_W / FILL_CYCLES : call-stack size, pointer width, pipeline fill length
//   opcode_t      : decoded EX operation
//   cond_flag_t   : condition selector (Z, NZ, C, NC)
//   flow_class_t  : flow-control class of an opcode
//   pc_sel_t      : PC source select
//   flow_state_t  : flow controller FSM state
package kcpsmx_flow_ctl_pkg;

   localparam int STACK_DEPTH = 31;
   localparam int SP_W        = 5;
   localparam int FILL_CYCLES = 2;

   typedef enum logic [4:0] {
      OP_LOAD      = 5'd0,
      OP_AND       = 5'd1,
      OP_OR        = 5'd2,
      OP_XOR       = 5'd3,
      OP_ADD       = 5'd4,
      OP_ADDCY     = 5'd5,
      OP_SUB       = 5'd6,
      OP_SUBCY     = 5'd7,
      OP_TEST      = 5'd8,
      OP_COMPARE   = 5'd9,
      OP_SR        = 5'd10,
      OP_SL        = 5'd11,
      OP_RR        = 5'd12,
      OP_RL        = 5'd13,
      OP_INPUT     = 5'd14,
      OP_OUTPUT    = 5'd15,
      OP_STORE     = 5'd16,
      OP_FETCH     = 5'd17,
      OP_JUMP      = 5'd18,
      OP_CALL      = 5'd19,
      OP_RETURN    = 5'd20,
      OP_RETURNI   = 5'd21,
      OP_INTERRUPT = 5'd22
   } opcode_t;

   typedef enum logic [1:0] {
      COND_Z  = 2'b00,
      COND_NZ = 2'b01,
      COND_C  = 2'b10,
      COND_NC = 2'b11
   } cond_flag_t;

   typedef enum logic [2:0] {
      FC_NONE   = 3'd0,
      FC_JUMP   = 3'd1,
      FC_CALL   = 3'd2,
      FC_RET    = 3'd3,
      FC_RETI   = 3'd4,
      FC_INTCTL = 3'd5
   } flow_class_t;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_STACK  = 2'd2,
      PC_VECTOR = 2'd3
   } pc_sel_t;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      RUN    = 2'd1,
      BUBBLE = 2'd2,
      IRQ    = 2'd3
   } flow_state_t;

endpackage

// File: rtl/kcpsmx_flow_ctl_flow_class.sv
// Opcode to flow-class decode (purely combinational).
//   operation  : EX opcode
//   flow_class : flow-control class; FC_NONE for every non-flow opcode
module kcpsmx_flow_class
   import kcpsmx_flow_ctl_pkg::*;
(
   input  opcode_t     operation,
   output flow_class_t flow_class
);

   always_comb begin
      flow_class = FC_NONE;
      case (operation)
         OP_JUMP:      flow_class = FC_JUMP;
         OP_CALL:      flow_class = FC_CALL;
         OP_RETURN:    flow_class = FC_RET;
         OP_RETURNI:   flow_class = FC_RETI;
         OP_INTERRUPT: flow_class = FC_INTCTL;
         default:      flow_class = FC_NONE;
      endcase
   end

endmodule

// File: rtl/kcpsmx_flow_ctl.sv
// Pipeline flow controller for the KCPSMX core. Resolves JUMP/CALL/RETURN/
// RETURNI and ENABLE/DISABLE INTERRUPT for the instruction in EX and drives
// PC source, IF/ID flush, call-stack push/pop, stack pointer, interrupt-enable
// flag and interrupt entry.
//   Inputs : clk, reset_n (async, active-low), ex_valid, operation,
//            conditional, condition_flags, interrupt_enable, zero, carry,
//            interrupt (level)
//   Outputs: fetch_en, flush, pc_sel, stack_push, stack_pop, stack_ptr, ie,
//            interrupt_ack, save_flags, restore_flags, stack_err
// Build option: KCPSMX_STACK_CHECK_EN enables the sticky stack over/underflow
// flag stack_err; without it stack_err is tied low.
//
// state  | meaning
// FILL   | pipeline filling after reset, EX ignored for FILL_CYCLES cycles
// RUN    | EX instruction resolved, interrupts accepted
// BUBBLE | one cycle after any flush, EX holds a killed instruction
// IRQ    | interrupt entry: vector, push return address, save flags
module kcpsmx_flow_ctl
   import kcpsmx_flow_ctl_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ex_valid,
   input  opcode_t          operation,
   input  logic             conditional,
   input  cond_flag_t       condition_flags,
   input  logic             interrupt_enable,
   input  logic             zero,
   input  logic             carry,
   input  logic             interrupt,
   output logic             fetch_en,
   output logic             flush,
   output pc_sel_t          pc_sel,
   output logic             stack_push,
   output logic             stack_pop,
   output logic [SP_W-1:0]  stack_ptr,
   output logic             ie,
   output logic             interrupt_ack,
   output logic             save_flags,
   output logic             restore_flags,
   output logic             stack_err
);

   localparam int FC_W = $clog2(FILL_CYCLES + 1);

   flow_state_t     state;
   logic [FC_W-1:0] fill_cnt;
   logic [SP_W-1:0] sp_q;
   logic            ie_q;
   logic            irq_q;
   logic            fetch_q;

   flow_class_t     fclass;
   logic            cond_ok;
   logic            taken;
   logic            ie_upd;
   logic            irq_accept;

   kcpsmx_flow_class u_flow_class (
      .operation  (operation),
      .flow_class (fclass)
   );

   always_comb begin
      case (condition_flags)
         COND_Z:  cond_ok = zero;
         COND_NZ: cond_ok = !zero;
         COND_C:  cond_ok = carry;
         default: cond_ok = !carry;
      endcase
      taken = !conditional || cond_ok;
   end

   always_comb begin
      pc_sel        = PC_SEQ;
      flush         = 1'b0;
      stack_push    = 1'b0;
      stack_pop     = 1'b0;
      interrupt_ack = 1'b0;
      save_flags    = 1'b0;
      restore_flags = 1'b0;
      ie_upd        = 1'b0;
      case (state)
         RUN: begin
            if (ex_valid) begin
               case (fclass)
                  FC_JUMP: if (taken) begin
                     pc_sel = PC_BRANCH;
                     flush  = 1'b1;
                  end
                  FC_CALL: if (taken) begin
                     pc_sel     = PC_BRANCH;
                     flush      = 1'b1;
                     stack_push = 1'b1;
                  end
                  FC_RET: if (taken) begin
                     pc_sel    = PC_STACK;
                     flush     = 1'b1;
                     stack_pop = 1'b1;
                  end
                  // RETURNI ignores the condition field
                  FC_RETI: begin
                     pc_sel        = PC_STACK;
                     flush         = 1'b1;
                     stack_pop     = 1'b1;
                     restore_flags = 1'b1;
                     ie_upd        = 1'b1;
                  end
                  FC_INTCTL: ie_upd = 1'b1;
                  default: ;
               endcase
            end
         end
         IRQ: begin
            pc_sel        = PC_VECTOR;
            flush         = 1'b1;
            stack_push    = 1'b1;
            save_flags    = 1'b1;
            interrupt_ack = 1'b1;
         end
         default: ;
      endcase
      // Flow ops and ie writes take precedence; the request stays in irq_q
      // and is looked at again on the next RUN cycle.
      irq_accept = (state == RUN) && irq_q && ie_q && !flush && !ie_upd;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= FILL;
         fill_cnt <= '0;
         sp_q     <= '0;
         ie_q     <= 1'b0;
         irq_q    <= 1'b0;
         fetch_q  <= 1'b0;
      end else begin
         fetch_q <= 1'b1;
         irq_q   <= interrupt;

         // Pointer wraps in both directions, matching KCPSMX3
         if (stack_push)
            sp_q <= sp_q + SP_W'(1);
         else if (stack_pop)
            sp_q <= sp_q - SP_W'(1);

         if (state == IRQ)
            ie_q <= 1'b0;
         else if (ie_upd)
            ie_q <= interrupt_enable;

         case (state)
            FILL: begin
               if (fill_cnt == FC_W'(FILL_CYCLES - 1))
                  state <= RUN;
               else
                  fill_cnt <= fill_cnt + FC_W'(1);
            end
            RUN: begin
               if (flush)
                  state <= BUBBLE;
               else if (irq_accept)
                  state <= IRQ;
            end
            BUBBLE: state <= RUN;
            IRQ:    state <= BUBBLE;
            default: state <= FILL;
         endcase
      end
   end

`ifdef KCPSMX_STACK_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         err_q <= 1'b0;
      else if ((stack_push && sp_q == SP_W'(STACK_DEPTH)) ||
               (stack_pop && sp_q == '0))
         err_q <= 1'b1;
   end

   assign stack_err = err_q;
`else
   assign stack_err = 1'b0;
`endif

   assign fetch_en  = fetch_q;
   assign stack_ptr = sp_q;
   assign ie        = ie_q;

endmodule
